raster_to_block: RTL and testbench
==================================

RASTER_TO_BLOCK -- requirements
Module: raster_to_block

Interface
REQ-001 SHALL have parameter DATA_W, default 24, pixel width in bits.
REQ-002 SHALL have parameter WIDTH, default 1280, pixels per line; a multiple of BLK.
REQ-003 SHALL have parameter BLK, default 8, block edge in pixels; a power of 2, 2..16.
REQ-004 SHALL have parameter NUM_BUF, default 2, number of band banks; 2..4.
REQ-005 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port sof  input  1  start of frame; qualified by in_valid and in_ready.
REQ-008 SHALL have port in_valid  input  1  raster pixel valid.
REQ-009 SHALL have port in_data  input  DATA_W  raster pixel.
REQ-010 SHALL have port in_ready  output  1  write bank has space.
REQ-011 SHALL have port out_valid  output  1  block-order pixel valid.
REQ-012 SHALL have port out_data  output  DATA_W  block-order pixel.
REQ-013 SHALL have port out_ready  input  1  downstream accepts the pixel.
REQ-014 SHALL have port out_sob / out_eob  output  1 each  first / last pixel of a BLK x BLK block.
REQ-015 SHALL have port out_last  output  1  last pixel of a band.
REQ-016 SHALL have port overflow  output  1  sticky flag: a pixel was dropped.
REQ-017 SHALL have port clr_overflow  input  1  clears overflow.

Function
REQ-018 SHALL hold NUM_BUF banks, each storing BLK lines x WIDTH pixels, with write address {line, hcnt}, 1-cycle read latency and per-bank full flags.
REQ-019 SHALL accept a pixel when in_valid && in_ready; hcnt counts 0..WIDTH-1, then line increments, wrapping to 0 after BLK-1.
REQ-020 SHALL drive in_ready = !full[wr_ptr].
REQ-021 SHALL, on acceptance of pixel (line=BLK-1, hcnt=WIDTH-1), set full[wr_ptr] on the next edge, advance wr_ptr modulo NUM_BUF, and zero hcnt and line.
REQ-022 SHALL treat an accepted pixel with sof=1 as hcnt=0, line=0 of the current bank, discarding that bank's partial band.
REQ-023 SHALL, when in_valid && !in_ready, drop the pixel, not advance the counters, and set overflow on the next edge.
REQ-024 SHALL clear overflow on clr_overflow; when set and clear coincide, set wins.
REQ-025 SHALL run the read FSM in states IDLE and SCAN; IDLE -> SCAN when full[rd_ptr]=1.
REQ-026 SHALL scan banks oldest-first in order col (fastest), then row, then block index mcu 0..WIDTH/BLK-1, reading address {row, mcu*BLK+col}.
REQ-027 SHALL, in the cycle the last read of a bank is issued, clear full[rd_ptr] on the next edge and advance rd_ptr.
REQ-028 SHALL, on that cycle, stay in SCAN when the next bank is full, inserting no bubble; otherwise it SHALL go to IDLE.
REQ-029 SHALL handle full-flag set and clear on different banks in the same cycle independently.
REQ-030 SHALL provide a registered output stage with skid capacity ensuring no pixel is lost or duplicated under any out_ready pattern.
REQ-031 SHALL hold out_data, out_sob, out_eob and out_last stable while out_valid && !out_ready.
REQ-032 SHALL, with out_ready=1, raise the first out_valid of a band exactly 3 cycles after the cycle that accepted its last pixel, then sustain 1 pixel per cycle.
REQ-033 SHALL assert out_sob at row=0, col=0; out_eob at row=BLK-1, col=BLK-1; out_last at out_eob of the last mcu.
REQ-034 SHALL stall read issue whenever the skid stage is full.

Reset
REQ-035 SHALL, on rst_n low, asynchronously set: all full flags=0, wr_ptr=rd_ptr=0, counters=0, FSM=IDLE, out_valid=0, out_sob=out_eob=out_last=0, out_data=0, overflow=0, in_ready=1.
REQ-036 SHALL, when reset is asserted mid-band or mid-scan, discard all buffered data; the first band after release SHALL be output correctly.

Verification (WIDTH=16, BLK=8, NUM_BUF=2, DATA_W=24, pixel value = 16*line+hcnt)
REQ-037 SHALL cover: 128 pixels with out_ready=1 -> out_data 0..7,16..23,...,112..119 (eob on 119), then 8..15,...,127 with out_last on 127; first out_valid 3 cycles after the last accept.
REQ-038 SHALL cover: the same band with out_ready toggling 1,0,1,0 -> identical 128-pixel sequence, data stable during stalls.
REQ-039 SHALL cover: out_ready=0 and 3 bands offered continuously -> in_ready=0 after pixel 256, overflow=1 on the next offered pixel, clr_overflow -> overflow=0.
REQ-040 SHALL cover: 40 pixels, then sof with a new band -> output contains only post-sof values 0..127.
REQ-041 SHALL cover: rst_n low for 1 cycle mid-scan -> out_valid=0, in_ready=1, overflow=0; the next band outputs correctly.
REQ-042 SHALL cover: 2 bands back-to-back with out_ready=1 -> 256 consecutive out_valid cycles, no bubble.

Source files
------------

// File: rtl/raster_to_block.sv
// raster_to_block
// Converts a raster pixel stream into BLK x BLK block order. Incoming lines
// are written into one of NUM_BUF band banks (BLK lines each); a full bank
// is read back block by block (col fastest, then row, then block index) and
// presented through a two-entry registered output stage.
//
// Handshake rules (both ports): a transfer happens on a rising edge where
// valid && ready. The producer holds valid and its payload until that edge;
// ready may depend combinationally on the receiver's registered state only.
// A pixel offered with in_valid while in_ready is low is dropped and sets
// the sticky overflow flag.
//
// The read-side FSM state is visible internally as rd_state for checkers.

module raster_to_block #(
    parameter int DATA_W  = 24,
    parameter int WIDTH   = 1280,
    parameter int BLK     = 8,
    parameter int NUM_BUF = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sof,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              out_sob,
    output logic              out_eob,
    output logic              out_last,
    output logic              overflow,
    input  logic              clr_overflow
);

    // Address field widths: {bank, line, hcnt}. Because BLK is a power of 2,
    // mcu*BLK+col is simply the concatenation {mcu, col}.
    localparam int HW    = $clog2(WIDTH);
    localparam int LW    = $clog2(BLK);
    localparam int MCUS  = WIDTH / BLK;
    localparam int MW    = (MCUS > 1) ? $clog2(MCUS) : 1;
    localparam int BW    = $clog2(NUM_BUF);
    localparam int AW    = BW + LW + HW;
    localparam int DEPTH = NUM_BUF << (LW + HW);
    localparam int PW    = DATA_W + 3;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } rd_state_t;

    function automatic logic [BW-1:0] next_ptr(input logic [BW-1:0] p);
        return (p == BW'(NUM_BUF - 1)) ? '0 : p + BW'(1);
    endfunction

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic [BW-1:0]      wr_ptr;
    logic [HW-1:0]      hcnt;
    logic [LW-1:0]      line;
    logic [NUM_BUF-1:0] full;
    logic [NUM_BUF-1:0] full_set;
    logic [NUM_BUF-1:0] full_clr;
    logic               wr_en;
    logic               wr_last;
    logic               hcnt_end;
    logic               line_end;
    logic [AW-1:0]      wr_addr;

    assign in_ready = !full[wr_ptr];
    assign wr_en    = in_valid && in_ready;
    assign hcnt_end = (hcnt == HW'(WIDTH - 1));
    assign line_end = (line == LW'(BLK - 1));
    // A pixel carrying sof lands at (0,0) and can never close a band.
    assign wr_last  = wr_en && !sof && hcnt_end && line_end;
    assign wr_addr  = sof ? {wr_ptr, {(LW + HW){1'b0}}} : {wr_ptr, line, hcnt};

    // Raster position counters and write bank pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            hcnt   <= '0;
            line   <= '0;
        end else if (wr_en) begin
            if (sof) begin
                // Restart the current bank; its partial band is abandoned.
                hcnt <= HW'(1);
                line <= '0;
            end else if (hcnt_end) begin
                hcnt <= '0;
                if (line_end) begin
                    line   <= '0;
                    wr_ptr <= next_ptr(wr_ptr);
                end else begin
                    line <= line + LW'(1);
                end
            end else begin
                hcnt <= hcnt + HW'(1);
            end
        end
    end

    // Sticky drop flag; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (in_valid && !in_ready) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    rd_state_t     rd_state;
    rd_state_t     rd_state_d;
    logic [BW-1:0] rd_ptr;
    logic [BW-1:0] rd_ptr_nxt;
    logic [LW-1:0] col;
    logic [LW-1:0] row;
    logic [MW-1:0] mcu;
    logic          col_end;
    logic          row_end;
    logic          mcu_end;
    logic          rd_issue;
    logic          rd_last;
    logic [AW-1:0] rd_addr;

    // Output stage registers (declared here because issue depends on them).
    logic [PW-1:0] out_pl;
    logic [PW-1:0] skid_pl;
    logic          skid_valid;
    logic          rd_vld;
    logic          rd_sob;
    logic          rd_eob;
    logic          rd_lst;
    logic [PW-1:0] rd_pl;

    assign col_end    = (col == LW'(BLK - 1));
    assign row_end    = (row == LW'(BLK - 1));
    assign mcu_end    = (mcu == MW'(MCUS - 1));
    assign rd_ptr_nxt = next_ptr(rd_ptr);
    assign rd_addr    = {rd_ptr, row, HW'({mcu, col})};

    // Issue only when the pixel it returns next cycle is sure to have a slot:
    // never with the skid entry occupied, and not when the output register is
    // stalled while another read is already landing (that one takes the skid).
    assign rd_issue = (rd_state == SCAN) && !skid_valid &&
                      !(out_valid && !out_ready && rd_vld);
    assign rd_last  = rd_issue && col_end && row_end && mcu_end;

    // Per-bank full flags: set and clear always target different banks.
    always_comb begin
        full_set = '0;
        full_clr = '0;
        for (int i = 0; i < NUM_BUF; i++) begin
            full_set[i] = wr_last && (wr_ptr == BW'(i));
            full_clr[i] = rd_last && (rd_ptr == BW'(i));
        end
    end

    // Full flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= '0;
        end else begin
            full <= (full & ~full_clr) | full_set;
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= IDLE;
        end else begin
            rd_state <= rd_state_d;
        end
    end

    // Read FSM next state: chain straight into the next bank when it is ready.
    always_comb begin
        rd_state_d = rd_state;
        case (rd_state)
            IDLE: begin
                if (full[rd_ptr]) begin
                    rd_state_d = SCAN;
                end
            end
            SCAN: begin
                if (rd_last) begin
                    rd_state_d = full[rd_ptr_nxt] ? SCAN : IDLE;
                end
            end
            default: rd_state_d = IDLE;
        endcase
    end

    // Block-order scan counters and read bank pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col    <= '0;
            row    <= '0;
            mcu    <= '0;
            rd_ptr <= '0;
        end else if (rd_issue) begin
            if (col_end) begin
                col <= '0;
                if (row_end) begin
                    row <= '0;
                    if (mcu_end) begin
                        mcu    <= '0;
                        rd_ptr <= rd_ptr_nxt;
                    end else begin
                        mcu <= mcu + MW'(1);
                    end
                end else begin
                    row <= row + LW'(1);
                end
            end else begin
                col <= col + LW'(1);
            end
        end
    end

    // Bank memory: raster writes, one-cycle registered block-order reads.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= in_data;
        end
        if (rd_issue) begin
            rd_data <= mem[rd_addr];
        end
    end

    // Markers travel alongside the memory read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld <= 1'b0;
            rd_sob <= 1'b0;
            rd_eob <= 1'b0;
            rd_lst <= 1'b0;
        end else begin
            rd_vld <= rd_issue;
            if (rd_issue) begin
                rd_sob <= (col == '0) && (row == '0);
                rd_eob <= col_end && row_end;
                rd_lst <= col_end && row_end && mcu_end;
            end
        end
    end

    assign rd_pl = {rd_lst, rd_eob, rd_sob, rd_data};

    // ------------------------------------------------------------------
    // Output stage: out_pl is the head, skid_pl catches a pixel that lands
    // while the head is stalled. The head only changes when empty or popped.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_pl     <= '0;
            skid_valid <= 1'b0;
            skid_pl    <= '0;
        end else if (!out_valid || out_ready) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_pl     <= skid_pl;
                skid_valid <= rd_vld;
                if (rd_vld) begin
                    skid_pl <= rd_pl;
                end
            end else begin
                out_valid <= rd_vld;
                if (rd_vld) begin
                    out_pl <= rd_pl;
                end
            end
        end else if (rd_vld) begin
            skid_valid <= 1'b1;
            skid_pl    <= rd_pl;
        end
    end

    assign out_data = out_pl[DATA_W-1:0];
    assign out_sob  = out_pl[DATA_W];
    assign out_eob  = out_pl[DATA_W+1];
    assign out_last = out_pl[DATA_W+2];

endmodule

// File: tb/tb_raster_to_block.sv
// Bench for raster_to_block with WIDTH=16, BLK=8, NUM_BUF=2, DATA_W=24.
// A band model rebuilds block order from raster positions and feeds an
// expected queue; a negedge process compares every output transfer.

module tb_raster_to_block;

    localparam int DATA_W  = 24;
    localparam int WIDTH   = 16;
    localparam int BLK     = 8;
    localparam int NUM_BUF = 2;
    localparam int BAND    = WIDTH * BLK;
    localparam int MCUS    = WIDTH / BLK;
    localparam int PW      = DATA_W + 3;

    logic              clk;
    logic              rst_n;
    logic              sof;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              out_sob;
    logic              out_eob;
    logic              out_last;
    logic              overflow;
    logic              clr_overflow;

    raster_to_block #(
        .DATA_W (DATA_W),
        .WIDTH  (WIDTH),
        .BLK    (BLK),
        .NUM_BUF(NUM_BUF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sof         (sof),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .out_sob     (out_sob),
        .out_eob     (out_eob),
        .out_last    (out_last),
        .overflow    (overflow),
        .clr_overflow(clr_overflow)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", 0);
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int fails  = 0;

    logic [PW-1:0]     exp_q[$];
    logic [DATA_W-1:0] got_q[$];
    logic [DATA_W-1:0] band_buf [BAND];
    int band_pos         = 0;
    int last_acc_edge    = 0;
    int first_valid_edge = -1;
    int eob_cnt          = 0;
    int last_cnt         = 0;
    int run_len          = 0;
    int max_run          = 0;
    int rdy_mode         = 1;   // 0: hold low, 1: always high, 2: toggle
    logic          prev_stall = 1'b0;
    logic [PW-1:0] prev_pl    = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Band model: store raster pixels; when a band completes, emit it in
    // block order with its markers.
    task automatic model_accept(input logic [DATA_W-1:0] d, input logic s);
        logic [PW-1:0] e;
        int idx;
        if (s) band_pos = 0;
        band_buf[band_pos] = d;
        band_pos++;
        if (band_pos == BAND) begin
            for (int m = 0; m < MCUS; m++)
                for (int r = 0; r < BLK; r++)
                    for (int c = 0; c < BLK; c++) begin
                        idx = r * WIDTH + m * BLK + c;
                        e[DATA_W-1:0] = band_buf[idx];
                        e[DATA_W]     = (r == 0) && (c == 0);
                        e[DATA_W+1]   = (r == BLK-1) && (c == BLK-1);
                        e[DATA_W+2]   = (r == BLK-1) && (c == BLK-1) && (m == MCUS-1);
                        exp_q.push_back(e);
                    end
            band_pos = 0;
        end
    endtask

    // ---------------- out_ready pattern ----------------
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b0;
                2:       out_ready = ~out_ready;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        logic [PW-1:0] act;
        logic [PW-1:0] exp;
        act = {out_last, out_eob, out_sob, out_data};
        if (!rst_n) begin
            prev_stall = 1'b0;
            run_len    = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_payload", 64'(act), 64'(prev_pl));
            end
            if (out_valid) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (first_valid_edge < 0) first_valid_edge = edge_cnt;
            end else begin
                run_len = 0;
            end
            if (out_valid && out_ready) begin
                chk("output_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    exp = exp_q.pop_front();
                    chk("out_pixel", 64'(act), 64'(exp));
                end
                got_q.push_back(out_data);
                if (out_eob) eob_cnt++;
                if (out_last) last_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_pl    = act;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [DATA_W-1:0] d, input logic s, input logic exp_acc);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = d;
        sof      = s;
        #1;
        chk("in_ready", 64'(in_ready), 64'(exp_acc));
        if (exp_acc) begin
            model_accept(d, s);
            last_acc_edge = edge_cnt + 1;
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sof      = 1'b0;
    endtask

    // One band with pixel value 16*line+hcnt (equal to the raster index).
    task automatic send_band(input logic with_sof);
        for (int i = 0; i < BAND; i++) send(DATA_W'(i), with_sof && (i == 0), 1'b1);
    endtask

    task automatic start_capture();
        got_q.delete();
        first_valid_edge = -1;
        eob_cnt  = 0;
        last_cnt = 0;
        max_run  = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (6) @(posedge clk);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int n;
        rst_n        = 1'b0;
        sof          = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        clr_overflow = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_markers", 64'({out_sob, out_eob, out_last}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_overflow", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // One band, out_ready high: order, markers, latency.
        rdy_mode = 1;
        start_capture();
        send_band(1'b0);
        idle();
        drain();
        chk("t1_count", 64'(got_q.size()), 64'd128);
        chk("t1_first", 64'(got_q[0]), 64'd0);
        chk("t1_row0_end", 64'(got_q[7]), 64'd7);
        chk("t1_row1_start", 64'(got_q[8]), 64'd16);
        chk("t1_blk0_end", 64'(got_q[63]), 64'd119);
        chk("t1_blk1_start", 64'(got_q[64]), 64'd8);
        chk("t1_last", 64'(got_q[127]), 64'd127);
        chk("t1_eob_count", 64'(eob_cnt), 64'd2);
        chk("t1_last_count", 64'(last_cnt), 64'd1);
        chk("t1_latency", 64'(first_valid_edge), 64'(last_acc_edge + 3));

        // Same band, out_ready toggling.
        rdy_mode = 2;
        start_capture();
        send_band(1'b0);
        idle();
        drain();
        chk("t2_count", 64'(got_q.size()), 64'd128);
        chk("t2_blk1_start", 64'(got_q[64]), 64'd8);
        chk("t2_last", 64'(got_q[127]), 64'd127);

        // Two bands back-to-back: one unbroken run of valid pixels.
        rdy_mode = 1;
        repeat (4) @(posedge clk);
        start_capture();
        send_band(1'b0);
        send_band(1'b0);
        idle();
        drain();
        chk("t3_count", 64'(got_q.size()), 64'd256);
        chk("t3_no_bubble", 64'(max_run), 64'd256);

        // Partial band abandoned by sof.
        start_capture();
        for (int i = 0; i < 40; i++) send(DATA_W'(i + 500), 1'b0, 1'b1);
        send_band(1'b1);
        idle();
        drain();
        chk("t4_count", 64'(got_q.size()), 64'd128);
        chk("t4_first", 64'(got_q[0]), 64'd0);
        chk("t4_last", 64'(got_q[127]), 64'd127);

        // Backpressure: both banks fill, further pixels are dropped.
        rdy_mode = 0;
        repeat (4) @(posedge clk);
        start_capture();
        for (int i = 0; i < 260; i++) begin
            send(DATA_W'(i % BAND), 1'b0, (i < 256) ? 1'b1 : 1'b0);
            if (i == 256) chk("t5_overflow_pre", 64'(overflow), 64'd0);
            if (i == 257) chk("t5_overflow_set", 64'(overflow), 64'd1);
        end
        idle();
        chk("t5_in_ready_low", 64'(in_ready), 64'd0);
        chk("t5_overflow_sticky", 64'(overflow), 64'd1);
        @(posedge clk);
        #1;
        clr_overflow = 1'b1;
        @(posedge clk);
        #1;
        clr_overflow = 1'b0;
        #1;
        chk("t5_overflow_clr", 64'(overflow), 64'd0);
        rdy_mode = 1;
        drain();
        chk("t5_count", 64'(got_q.size()), 64'd256);

        // Reset in the middle of a scan, then a clean band.
        start_capture();
        send_band(1'b0);
        idle();
        n = 0;
        while (got_q.size() < 20 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("t6_scan_started", 64'(got_q.size() >= 20), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        band_pos = 0;
        #1;
        chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_in_ready", 64'(in_ready), 64'd1);
        chk("t6_rst_overflow", 64'(overflow), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start_capture();
        send_band(1'b0);
        idle();
        drain();
        chk("t6_count", 64'(got_q.size()), 64'd128);
        chk("t6_first", 64'(got_q[0]), 64'd0);
        chk("t6_last", 64'(got_q[127]), 64'd127);
        chk("t6_latency", 64'(first_valid_edge), 64'(last_acc_edge + 3));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
